// File: rtl/alu_share_ctrl_if.sv
// Bundle between the ALU sharing controller, its two requesters, the shared ALU
// and the response consumer. The controller takes the slave view; the environment takes master.
interface alu_share_ctrl_if #(
  parameter int W = 64
);
  logic         req0_valid;
  logic         req0_ready;
  logic [1:0]   req0_op;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic         req0_setcc;

  logic         req1_valid;
  logic         req1_ready;
  logic [1:0]   req1_op;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic         req1_setcc;

  logic [1:0]   alu_opcode;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_res;
  logic         alu_zero;
  logic         alu_overflow;

  logic         resp_valid;
  logic         resp_ready;
  logic         resp_id;
  logic [W-1:0] resp_res;
  logic         resp_zero;
  logic         resp_overflow;

  logic         cc_zf;
  logic         cc_sf;
  logic         cc_of;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_setcc,
    input  req1_valid, req1_op, req1_a, req1_b, req1_setcc,
    input  alu_res, alu_zero, alu_overflow,
    input  resp_ready,
    output req0_ready, req1_ready,
    output alu_opcode, alu_a, alu_b,
    output resp_valid, resp_id, resp_res, resp_zero, resp_overflow,
    output cc_zf, cc_sf, cc_of
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_setcc,
    output req1_valid, req1_op, req1_a, req1_b, req1_setcc,
    output alu_res, alu_zero, alu_overflow,
    output resp_ready,
    input  req0_ready, req1_ready,
    input  alu_opcode, alu_a, alu_b,
    input  resp_valid, resp_id, resp_res, resp_zero, resp_overflow,
    input  cc_zf, cc_sf, cc_of
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Time-shares one external combinational ALU between two requesters and owns {ZF,SF,OF}.
// Define ALU_SHARE_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_share_ctrl #(
  parameter int         W      = 64,
  parameter logic [2:0] CC_RST = 3'b100
) (
  input logic             clk,
  input logic             rst,
  alu_share_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [1:0]   op_q, op_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic         setcc_q, setcc_d;
  logic         id_q, id_d;
  logic         last_grant_q, last_grant_d;

  logic         resp_id_q, resp_id_d;
  logic [W-1:0] resp_res_q, resp_res_d;
  logic         resp_zero_q, resp_zero_d;
  logic         resp_ovf_q, resp_ovf_d;
  logic [2:0]   cc_q, cc_d;

  logic grant1;
  logic accept;
  logic req0_ready;
  logic req1_ready;
  logic resp_valid;

  // grant1 selects requester 1; it is only meaningful while someone is valid.
  always_comb begin
    grant1 = 1'b0;
`ifdef ALU_SHARE_RR_EN
    if (bus.req0_valid && bus.req1_valid) begin
      grant1 = ~last_grant_q;
    end else begin
      grant1 = bus.req1_valid;
    end
`else
    grant1 = bus.req1_valid && !bus.req0_valid;
`endif
  end

  assign accept = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req0_ready = bus.req0_valid && !grant1;
        req1_ready = bus.req1_valid && grant1;
      end
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand latch on accept; result and CC capture on the EXEC edge.
  always_comb begin
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    setcc_d      = setcc_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    resp_id_d    = resp_id_q;
    resp_res_d   = resp_res_q;
    resp_zero_d  = resp_zero_q;
    resp_ovf_d   = resp_ovf_q;
    cc_d         = cc_q;
    if (accept) begin
      op_d         = grant1 ? bus.req1_op    : bus.req0_op;
      a_d          = grant1 ? bus.req1_a     : bus.req0_a;
      b_d          = grant1 ? bus.req1_b     : bus.req0_b;
      setcc_d      = grant1 ? bus.req1_setcc : bus.req0_setcc;
      id_d         = grant1;
      last_grant_d = grant1;
    end
    if (state_q == EXEC) begin
      resp_id_d   = id_q;
      resp_res_d  = bus.alu_res;
      resp_zero_d = bus.alu_zero;
      resp_ovf_d  = bus.alu_overflow;
      if (setcc_q) begin
        cc_d = {bus.alu_zero, bus.alu_res[W-1], bus.alu_overflow};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      setcc_q      <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      resp_id_q    <= 1'b0;
      resp_res_q   <= '0;
      resp_zero_q  <= 1'b0;
      resp_ovf_q   <= 1'b0;
      cc_q         <= CC_RST;
    end else begin
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      setcc_q      <= setcc_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      resp_id_q    <= resp_id_d;
      resp_res_q   <= resp_res_d;
      resp_zero_q  <= resp_zero_d;
      resp_ovf_q   <= resp_ovf_d;
      cc_q         <= cc_d;
    end
  end

  assign bus.req0_ready    = req0_ready;
  assign bus.req1_ready    = req1_ready;
  assign bus.alu_opcode    = op_q;
  assign bus.alu_a         = a_q;
  assign bus.alu_b         = b_q;
  assign bus.resp_valid    = resp_valid;
  assign bus.resp_id       = resp_id_q;
  assign bus.resp_res      = resp_res_q;
  assign bus.resp_zero     = resp_zero_q;
  assign bus.resp_overflow = resp_ovf_q;
  assign bus.cc_zf         = cc_q[2];
  assign bus.cc_sf         = cc_q[1];
  assign bus.cc_of         = cc_q[0];

endmodule
